register_file_param: RTL and testbench
======================================

// Module: register_file_param
// PURPOSE
//  Parametrised multi-port register file for the Galetron datapath; next generation of the fixed 32x32 file.
//  Adds generic width/depth, an optional hardwired-zero register and optional write-to-read bypass.
//  Adds a synchronous reset that runs a hardware clear sweep, with a ready flag for the control unit.
//  Sits between decode (addresses) and the ALU/memory stage (operands); written back at end of pipeline.
// PARAMETERS
//  DATA_WIDTH  32  bits per register
//  ADDR_WIDTH  5   address bits; DEPTH = 2**ADDR_WIDTH entries
//  ZERO_REG    0   1: entry 0 always reads 0, writes to entry 0 discarded
//  BYPASS      1   1: same-cycle write data forwarded to matching read ports
// PORTS
//  clock          in   1           rising-edge clock, single domain
//  reset          in   1           synchronous, active-high
//  writeRegister  in   1           write enable
//  writeAddress   in   ADDR_WIDTH  write address
//  writeData      in   DATA_WIDTH  write data
//  readAddress0   in   ADDR_WIDTH  read port A address (destination-operand read)
//  readAddress1   in   ADDR_WIDTH  read port B address
//  readAddress2   in   ADDR_WIDTH  read port C address
//  dataA          out  DATA_WIDTH  read port A data (combinational)
//  dataB          out  DATA_WIDTH  read port B data (combinational)
//  dataC          out  DATA_WIDTH  read port C data (combinational)
//  ready          out  1           1 = file cleared and accepting writes
// BEHAVIOUR
//  - FSM states CLEAR, RUN; sweep counter clr_cnt, ADDR_WIDTH bits.
//  - reset sampled 1 at an edge: state<=CLEAR, clr_cnt<=0, ready<=0; any write that cycle dropped.
//  - reset held high: stays CLEAR, clr_cnt held at 0, no entries cleared.
//  - CLEAR (reset low): each edge RF[clr_cnt]<=0, clr_cnt++; on edge clearing entry DEPTH-1: state<=RUN, ready<=1.
//  - ready rises exactly DEPTH edges after reset deasserts; clr_cnt never wraps (terminal at all-ones).
//  - CLEAR: writeRegister ignored; dataA/B/C forced to 0 regardless of address.
//  - RUN: writeRegister=1 -> RF[writeAddress]<=writeData at rising edge; visible from next cycle.
//  - Reads asynchronous: dataX = RF[readAddressX]; all three ports independent, may alias the same entry.
//  - BYPASS=1, RUN, writeRegister=1, readAddressX==writeAddress -> dataX=writeData same cycle.
//  - BYPASS=0: same-cycle read returns the old contents.
//  - ZERO_REG=1: readAddressX==0 -> dataX=0 (overrides bypass); writes to address 0 never stored.
//  - ZERO_REG=0: entry 0 is an ordinary register.
//  - reset mid-CLEAR: sweep restarts at 0; reset in RUN: all contents re-cleared, ready low DEPTH cycles.
//  - No X on outputs after first reset; before first reset contents undefined, ready undefined.
//  - No arithmetic beyond clr_cnt increment; writeData stored unmodified, full DATA_WIDTH.
// TESTING (DATA_WIDTH=32, ADDR_WIDTH=5 unless noted)
//  1 reset=1 one edge then 0 -> ready=0 for 32 edges, 1 after 32nd; all ports read 0x00000000 for every address.
//  2 RUN: write r5=0xDEADBEEF, next cycle readAddress1=5 -> dataB=0xDEADBEEF; dataA/dataC on r6 = 0.
//  3 BYPASS=1: write r7=0x12345678, readAddress2=7 same cycle -> dataC=0x12345678; BYPASS=0 -> dataC=0.
//  4 ZERO_REG=1: write r0=0xFFFFFFFF -> all ports at address 0 read 0, incl. same-cycle bypass; ZERO_REG=0 -> 0xFFFFFFFF.
//  5 writeRegister=1 to r3 during CLEAR -> r3 reads 0 after ready; reset pulse when clr_cnt=10 -> ready 32 edges later.
//  6 r9=0xA5A5A5A5 in RUN, then reset -> after ready r9=0; three ports on address 9 read identical values every cycle.

Source files
------------

// File: rtl/register_file_param.sv
// ============================================================================
// Module      : register_file_param
// Description : Parametrised 1W/3R register file with hardware clear sweep on
//               reset, optional hardwired-zero entry and write-to-read bypass.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module register_file_param #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int ZERO_REG   = 0,
    parameter int BYPASS     = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  writeRegister,
    input  logic [ADDR_WIDTH-1:0] writeAddress,
    input  logic [DATA_WIDTH-1:0] writeData,
    input  logic [ADDR_WIDTH-1:0] readAddress0,
    input  logic [ADDR_WIDTH-1:0] readAddress1,
    input  logic [ADDR_WIDTH-1:0] readAddress2,
    output logic [DATA_WIDTH-1:0] dataA,
    output logic [DATA_WIDTH-1:0] dataB,
    output logic [DATA_WIDTH-1:0] dataC,
    output logic                  ready
);

    localparam int                  C_DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] C_LAST = ADDR_WIDTH'(C_DEPTH - 1);

    typedef enum logic [0:0] {
        S_CLEAR = 1'b0,
        S_RUN   = 1'b1
    } state_t;

    state_t                  r_state;
    state_t                  w_state_next;
    logic [ADDR_WIDTH-1:0]   r_clr_cnt;
    logic [ADDR_WIDTH-1:0]   w_clr_cnt_next;
    logic                    r_ready;
    logic                    w_ready_next;

    logic [DATA_WIDTH-1:0]   r_mem [C_DEPTH];

    logic                    w_mem_we;
    logic [ADDR_WIDTH-1:0]   w_mem_addr;
    logic [DATA_WIDTH-1:0]   w_mem_data;

    logic [ADDR_WIDTH-1:0]   w_raddr [3];

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state   <= S_CLEAR;
            r_clr_cnt <= '0;
            r_ready   <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_clr_cnt <= w_clr_cnt_next;
            r_ready   <= w_ready_next;
        end
    end

    // Counter saturates at the last entry so it never wraps back into the file.
    always_comb begin
        w_state_next   = r_state;
        w_clr_cnt_next = r_clr_cnt;
        w_ready_next   = r_ready;
        case (r_state)
            S_CLEAR: begin
                if (r_clr_cnt == C_LAST) begin
                    w_state_next = S_RUN;
                    w_ready_next = 1'b1;
                end else begin
                    w_clr_cnt_next = r_clr_cnt + 1'b1;
                end
            end
            default: begin
                w_state_next = S_RUN;
            end
        endcase
    end

    // Single write port shared between the clear sweep and normal writeback.
    always_comb begin
        w_mem_we   = 1'b0;
        w_mem_addr = '0;
        w_mem_data = '0;
        if (!reset) begin
            if (r_state == S_CLEAR) begin
                w_mem_we   = 1'b1;
                w_mem_addr = r_clr_cnt;
            end else if (writeRegister &&
                         !((ZERO_REG != 0) && (writeAddress == '0))) begin
                w_mem_we   = 1'b1;
                w_mem_addr = writeAddress;
                w_mem_data = writeData;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (w_mem_we) begin
            r_mem[w_mem_addr] <= w_mem_data;
        end
    end

    assign w_raddr[0] = readAddress0;
    assign w_raddr[1] = readAddress1;
    assign w_raddr[2] = readAddress2;

    // Priority: clear forces zero, then hardwired zero, then bypass, then array.
    for (genvar gi = 0; gi < 3; gi++) begin : g_read
        logic [DATA_WIDTH-1:0] w_rdata;
        always_comb begin
            w_rdata = r_mem[w_raddr[gi]];
            if ((BYPASS != 0) && writeRegister && (w_raddr[gi] == writeAddress)) begin
                w_rdata = writeData;
            end
            if ((ZERO_REG != 0) && (w_raddr[gi] == '0)) begin
                w_rdata = '0;
            end
            if (r_state != S_RUN) begin
                w_rdata = '0;
            end
        end
    end

    assign dataA = g_read[0].w_rdata;
    assign dataB = g_read[1].w_rdata;
    assign dataC = g_read[2].w_rdata;
    assign ready = r_ready;

endmodule

`default_nettype wire

// File: tb/tb_register_file_param.sv
// ============================================================================
// Module      : tb_register_file_param
// Description : Directed self-checking bench for register_file_param in three
//               parameter flavours sharing one stimulus stream.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_register_file_param;

    logic        clock;
    logic        reset;
    logic        writeRegister;
    logic [4:0]  writeAddress;
    logic [31:0] writeData;
    logic [4:0]  readAddress0;
    logic [4:0]  readAddress1;
    logic [4:0]  readAddress2;

    logic [31:0] d_dataA, d_dataB, d_dataC;
    logic        d_ready;
    logic [31:0] n_dataA, n_dataB, n_dataC;
    logic        n_ready;
    logic [31:0] z_dataA, z_dataB, z_dataC;
    logic        z_ready;

    int checks = 0;
    int errors = 0;

    register_file_param #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .ZERO_REG(0), .BYPASS(1)) u_dut (
        .clock(clock), .reset(reset), .writeRegister(writeRegister),
        .writeAddress(writeAddress), .writeData(writeData),
        .readAddress0(readAddress0), .readAddress1(readAddress1), .readAddress2(readAddress2),
        .dataA(d_dataA), .dataB(d_dataB), .dataC(d_dataC), .ready(d_ready)
    );

    register_file_param #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .ZERO_REG(0), .BYPASS(0)) u_nb (
        .clock(clock), .reset(reset), .writeRegister(writeRegister),
        .writeAddress(writeAddress), .writeData(writeData),
        .readAddress0(readAddress0), .readAddress1(readAddress1), .readAddress2(readAddress2),
        .dataA(n_dataA), .dataB(n_dataB), .dataC(n_dataC), .ready(n_ready)
    );

    register_file_param #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .ZERO_REG(1), .BYPASS(1)) u_zr (
        .clock(clock), .reset(reset), .writeRegister(writeRegister),
        .writeAddress(writeAddress), .writeData(writeData),
        .readAddress0(readAddress0), .readAddress1(readAddress1), .readAddress2(readAddress2),
        .dataA(z_dataA), .dataB(z_dataB), .dataC(z_dataC), .ready(z_ready)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic edge_step();
        @(posedge clock);
        #1;
    endtask

    task automatic set_rd(input logic [4:0] a);
        readAddress0 = a;
        readAddress1 = a;
        readAddress2 = a;
    endtask

    initial begin
        reset         = 1'b1;
        writeRegister = 1'b0;
        writeAddress  = '0;
        writeData     = '0;
        set_rd(5'd0);

        // Reset held for several edges keeps the sweep parked.
        repeat (3) edge_step();
        chk("ready_in_reset", {31'd0, d_ready}, 32'd0);
        chk("zr_ready_in_reset", {31'd0, z_ready}, 32'd0);
        reset = 1'b0;

        // Writes to r3 attempted throughout the sweep must be lost.
        writeRegister = 1'b1;
        writeAddress  = 5'd3;
        writeData     = 32'h5555_AAAA;
        set_rd(5'd3);
        for (int i = 1; i <= 32; i++) begin
            edge_step();
            if (i == 10) chk("clear_forced_zero", d_dataA, 32'd0);
            if (i == 31) chk("ready_edge31", {31'd0, d_ready}, 32'd0);
            if (i == 32) chk("ready_edge32", {31'd0, d_ready}, 32'd1);
        end
        writeRegister = 1'b0;
        #1;
        chk("r3_write_in_clear_dropped", d_dataA, 32'd0);
        chk("nb_ready", {31'd0, n_ready}, 32'd1);
        chk("zr_ready", {31'd0, z_ready}, 32'd1);

        for (int a = 0; a < 32; a++) begin
            set_rd(5'(a));
            #1;
            chk("cleared_all_ports", d_dataA | d_dataB | d_dataC | n_dataA | z_dataC, 32'd0);
        end

        // Basic write then read next cycle.
        writeRegister = 1'b1;
        writeAddress  = 5'd5;
        writeData     = 32'hDEAD_BEEF;
        edge_step();
        writeRegister = 1'b0;
        readAddress0  = 5'd6;
        readAddress1  = 5'd5;
        readAddress2  = 5'd6;
        #1;
        chk("r5_portB", d_dataB, 32'hDEAD_BEEF);
        chk("r6_portA", d_dataA, 32'd0);
        chk("r6_portC", d_dataC, 32'd0);

        // Same-cycle bypass versus old contents.
        writeRegister = 1'b1;
        writeAddress  = 5'd7;
        writeData     = 32'h1234_5678;
        readAddress2  = 5'd7;
        #1;
        chk("bypass_on_portC", d_dataC, 32'h1234_5678);
        chk("bypass_off_portC", n_dataC, 32'd0);
        edge_step();
        writeRegister = 1'b0;
        #1;
        chk("nobypass_next_cycle", n_dataC, 32'h1234_5678);

        // Entry 0: hardwired zero versus ordinary register.
        writeRegister = 1'b1;
        writeAddress  = 5'd0;
        writeData     = 32'hFFFF_FFFF;
        set_rd(5'd0);
        #1;
        chk("zr_bypass_A", z_dataA, 32'd0);
        chk("zr_bypass_C", z_dataC, 32'd0);
        chk("r0_bypass_A", d_dataA, 32'hFFFF_FFFF);
        edge_step();
        writeRegister = 1'b0;
        #1;
        chk("zr_r0_A", z_dataA, 32'd0);
        chk("zr_r0_B", z_dataB, 32'd0);
        chk("zr_r0_C", z_dataC, 32'd0);
        chk("r0_stored_B", d_dataB, 32'hFFFF_FFFF);
        chk("nb_r0_stored_A", n_dataA, 32'hFFFF_FFFF);

        // Load r9, then reset from RUN must wipe it.
        writeRegister = 1'b1;
        writeAddress  = 5'd9;
        writeData     = 32'hA5A5_A5A5;
        edge_step();
        writeRegister = 1'b0;
        set_rd(5'd9);
        #1;
        chk("r9_A", d_dataA, 32'hA5A5_A5A5);
        chk("r9_B", d_dataB, 32'hA5A5_A5A5);
        chk("r9_C", d_dataC, 32'hA5A5_A5A5);

        reset = 1'b1;
        edge_step();
        reset = 1'b0;
        chk("ready_low_after_reset", {31'd0, d_ready}, 32'd0);
        repeat (10) edge_step();

        // Abort the sweep at clr_cnt=10; the full 32-edge sweep restarts.
        reset = 1'b1;
        edge_step();
        reset = 1'b0;
        for (int i = 1; i <= 32; i++) begin
            edge_step();
            chk("r9_sweep_A", d_dataA, 32'd0);
            chk("r9_sweep_B", d_dataB, 32'd0);
            chk("r9_sweep_C", d_dataC, 32'd0);
            if (i == 31) chk("restart_ready31", {31'd0, d_ready}, 32'd0);
            if (i == 32) chk("restart_ready32", {31'd0, d_ready}, 32'd1);
        end
        #1;
        chk("r9_cleared_A", d_dataA, 32'd0);
        chk("r9_cleared_B", d_dataB, 32'd0);
        chk("r9_cleared_C", d_dataC, 32'd0);
        set_rd(5'd5);
        #1;
        chk("r5_cleared", d_dataB, 32'd0);
        set_rd(5'd0);
        #1;
        chk("r0_cleared", d_dataA, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
